// File: rtl/freq_gate_counter_if.sv
// Signal bundle between the frequency-counter measurement core and its environment.
// The slave side is the measurement core; the master side drives sig_in and observes results.
interface freq_gate_counter_if;
    logic        sig_in;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        valid;
    logic        gate_active;

    modport master (output sig_in, input bcd_out, overflow, valid, gate_active);
    modport slave  (input sig_in, output bcd_out, overflow, valid, gate_active);
endinterface

// File: rtl/freq_gate_counter.sv
// Gated frequency measurement core: synchronises sig_in, counts its rising edges in four
// BCD decades over back-to-back windows of GATE_CYCLES clocks, and latches the result.
module freq_gate_counter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    freq_gate_counter_if.slave bus
);
    localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] TERMINAL = TW'(GATE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;
    logic                   edge_det;
    logic [TW-1:0]          timer_q;
    logic                   terminal;
    logic                   gate_q;
    logic [3:0][3:0]        digit_q;
    logic [3:0][3:0]        digit_inc;
    logic [3:0][3:0]        count_next;
    logic                   all_nines;
    logic                   sat_edge;
    logic                   ovf_acc_q;
    logic                   ovf_now;
    logic [15:0]            bcd_q;
    logic                   ovf_q;
    logic                   valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~delay_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            gate_q  <= 1'b0;
        end else begin
            gate_q  <= 1'b1;
            timer_q <= terminal ? '0 : timer_q + TW'(1);
        end
    end

    assign terminal = (timer_q == TERMINAL);

    // Ripple the increment through the decades; a digit at 9 wraps and passes the carry on.
    always_comb begin
        logic carry;
        carry     = edge_det;
        all_nines = 1'b1;
        for (int d = 0; d < 4; d++) begin
            digit_inc[d] = digit_q[d];
            all_nines    = all_nines & (digit_q[d] == 4'd9);
            if (carry) begin
                if (digit_q[d] == 4'd9) begin
                    digit_inc[d] = 4'd0;
                end else begin
                    digit_inc[d] = digit_q[d] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    // At 9999 an edge must not wrap the count; it only raises the overflow.
    assign sat_edge   = edge_det & all_nines;
    assign count_next = sat_edge ? digit_q : digit_inc;
    assign ovf_now    = ovf_acc_q | sat_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q   <= '0;
            ovf_acc_q <= 1'b0;
        end else if (terminal) begin
            digit_q   <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            digit_q   <= count_next;
            ovf_acc_q <= ovf_now;
        end
    end

    // The closing window's result includes any edge arriving on the terminal cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= terminal;
            if (terminal) begin
                bcd_q <= count_next;
                ovf_q <= ovf_now;
            end
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.overflow    = ovf_q;
    assign bus.valid       = valid_q;
    assign bus.gate_active = gate_q;
endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Measurement core that sits directly upstream of the 7-segment display driver in the frequency counter.
- Synchronises the external test signal and counts its rising edges over a fixed gate window of clk cycles.
- Accumulates the count in 4 cascaded BCD decade counters, then latches the result once per window together with an overflow flag and a one-cycle valid strobe.
- The display driver consumes bcd_out and overflow directly.

Parameters:
- GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz); legal range 2..2^27-1.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchroniser; legal range 2..4.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  external signal under measurement; asynchronous to clk.
- bcd_out  output  16  latched count of the last complete window, 4 BCD digits, [15:12] = thousands.
- overflow  output  1  latched: last complete window exceeded 9999 edges.
- valid  output  1  one-cycle pulse when bcd_out/overflow update.
- gate_active  output  1  high while a window is in progress (low only in reset).

Behaviour:
- Reset (async assert, sync release via normal clocking):
  - bcd_out=16'h0000, overflow=0, valid=0, gate_active=0.
  - Synchroniser, edge register, gate timer and BCD counters are all cleared.
- Synchroniser and edge detect:
  - SYNC_STAGES-deep flop chain, followed by one extra delay flop.
  - edge = sync_last & ~delay.
  - Latency from a sig_in rise to the counter increment is SYNC_STAGES+1 clk edges.
  - A sig_in pulse narrower than one clk period may be missed; this is accepted.
- Gate timer:
  - Counter width is ceil(log2(GATE_CYCLES)).
  - First cycle after reset: gate_active rises and the timer runs 0..GATE_CYCLES-1.
  - At terminal count (timer == GATE_CYCLES-1) it wraps to 0 with no idle gap. Windows are back-to-back.
- BCD accumulation:
  - Each edge cycle increments digit0.
  - A digit at 9 that receives an increment rolls to 0 and carries into the next digit in the same cycle (combinational carry chain).
  - No digit ever holds a value above 9.
- Saturation:
  - An edge while the count is 9999 sets an internal ovf_acc flag.
  - The count holds at 9999 (no wrap).
  - ovf_acc is sticky for the rest of the window.
- Terminal-count cycle, all in the same clk edge:
  - bcd_out <= current count, including any edge in this cycle.
  - overflow <= ovf_acc, or an edge in this cycle while the count is 9999.
  - valid <= 1.
  - BCD counters and ovf_acc clear to 0.
- Edge exactly on the terminal-count cycle:
  - It is counted in the window that is closing.
  - The new window starts at 0000.
  - No edge is lost or double-counted.
- valid timing:
  - Exactly 1 cycle wide.
  - First assertion occurs GATE_CYCLES cycles after reset release.
  - Then every GATE_CYCLES cycles.
- Between strobes, bcd_out and overflow hold stable. Intermediate counts are never visible on outputs.
- Reset mid-window:
  - The partial count is discarded and outputs return to their reset values.
  - The next valid is GATE_CYCLES cycles after release.

Test Plan:
- GATE_CYCLES=100, sig_in toggles every 5 clk (period 10) -> every valid shows bcd_out=16'h0010, overflow=0; valid period = 100 cycles.
- GATE_CYCLES=100, sig_in held 0, then held 1 -> bcd_out=16'h0000 on every strobe; the single 0->1 transition yields 16'h0001 in exactly one window.
- GATE_CYCLES=2000, sig_in period 4 clk -> 500 edges/window -> bcd_out=16'h0500; then period 2 clk -> 1000 edges -> bcd_out=16'h1000. The latter checks the 0999->1000 triple carry.
- GATE_CYCLES=30000, sig_in period 2 clk (15000 edges) -> bcd_out=16'h9999, overflow=1. Switch to period 10 (3000 edges) -> next full window bcd_out=16'h3000, overflow=0.
- GATE_CYCLES=100, place one isolated edge so it reaches the counter on the terminal-count cycle -> it appears in that window's bcd_out (16'h0001); the following window reports 16'h0000.
- GATE_CYCLES=100, assert rst at cycle 50 of a window with 5 edges counted -> outputs go 0 immediately; after release, first valid arrives 100 cycles later with only post-reset edges counted.
